// File: rtl/i2c_cmd_seq.sv
// Command sequencer in front of the i2cm master: buffers host transactions in a
// small FIFO, issues them one at a time and returns one response per command.
module i2c_cmd_seq #(
    parameter int FIFO_DEPTH = 4,
    parameter int ACK_WAIT   = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [6:0]                    cmd_addr,
    input  logic                          cmd_rw,
    input  logic [7:0]                    cmd_wdata,
    output logic                          rsp_valid,
    output logic [7:0]                    rsp_rdata,
    output logic                          rsp_err,
    output logic                          m_enable,
    output logic [6:0]                    m_addr,
    output logic                          m_rw,
    output logic [7:0]                    m_data_in,
    input  logic [7:0]                    m_data_out,
    input  logic                          m_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (TIMEOUT > ACK_WAIT) ? TIMEOUT : ACK_WAIT;
    localparam int CW   = $clog2(CMAX);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_WAIT - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]     wr_ptr_d, rd_ptr_d;
    logic            empty, full, push, pop;
    logic [15:0]     head;

    // The extra MSB of each pointer tells a full FIFO from an empty one.
    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    assign pop        = (state_q == S_IDLE) && !empty && m_ready;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign busy       = (state_q != S_IDLE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_rw, cmd_addr, cmd_wdata};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            m_enable  <= 1'b0;
            m_addr    <= 7'h00;
            m_rw      <= 1'b0;
            m_data_in <= 8'h00;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q   <= S_ISSUE;
                        m_rw      <= head[15];
                        m_addr    <= head[14:8];
                        m_data_in <= head[7:0];
                        m_enable  <= 1'b1;
                        cnt_q     <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!m_ready) begin
                        state_q  <= S_WAIT_DONE;
                        m_enable <= 1'b0;
                        cnt_q    <= '0;
                    end else if (cnt_q == ACK_LAST) begin
                        state_q   <= S_RESP;
                        m_enable  <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 8'h00;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_WAIT_DONE: begin
                    // A ready seen on the last allowed cycle still counts as success.
                    if (m_ready) begin
                        state_q   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= m_rw ? m_data_out : 8'h00;
                    end else if (cnt_q == TO_LAST) begin
                        state_q   <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= 8'h00;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    state_q   <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= 8'h00;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_cmd_seq.sv
// Scoreboard bench for i2c_cmd_seq: a behavioural I2C master model plus a
// queue of expected responses derived from each command's master behaviour.
module tb_i2c_cmd_seq;
    localparam int DEPTH    = 4;
    localparam int ACK_WAIT = 16;
    localparam int TIMEOUT  = 4096;
    localparam int M_NORMAL = 0;
    localparam int M_NOACK  = 1;
    localparam int M_STUCK  = 2;

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        int         mode;
        int         d1;
        int         d2;
        logic [7:0] rd;
    } txn_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid, cmd_ready, cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic       m_enable, m_rw, m_ready, busy;
    logic [6:0] m_addr;
    logic [7:0] m_data_in, m_data_out;
    logic [2:0] fifo_level;

    txn_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   en_cnt   = 0;
    int   wait_cnt = 0;
    int   rsp_seen = 0;
    logic prev_en  = 1'b0;
    logic saw_full = 1'b0;
    txn_t mon_t;

    i2c_cmd_seq #(.FIFO_DEPTH(DEPTH), .ACK_WAIT(ACK_WAIT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_rw(cmd_rw), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_enable(m_enable), .m_addr(m_addr), .m_rw(m_rw), .m_data_in(m_data_in),
        .m_data_out(m_data_out), .m_ready(m_ready),
        .busy(busy), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Expected response and handshake durations from the master behaviour chosen for a command.
    function automatic void ref_rsp(input txn_t t, output logic [7:0] rd, output logic err,
                                    output int en, output int wt);
        if (t.mode == M_NOACK) begin
            rd = 8'h00; err = 1'b1; en = ACK_WAIT; wt = 0;
        end else if (t.mode == M_STUCK) begin
            rd = 8'h00; err = 1'b1; en = t.d1 + 1; wt = TIMEOUT;
        end else begin
            rd = t.rw ? t.rd : 8'h00; err = 1'b0; en = t.d1 + 1; wt = t.d2;
        end
    endfunction

    function automatic txn_t mk(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                                input int mode, input int d1, input int d2, input logic [7:0] rd);
        txn_t t;
        t.addr = a; t.rw = rw; t.wdata = wd; t.mode = mode; t.d1 = d1; t.d2 = d2; t.rd = rd;
        return t;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input txn_t t);
        bit noted = 0;
        bit ok = 0;
        cmd_valid = 1'b1; cmd_addr = t.addr; cmd_rw = t.rw; cmd_wdata = t.wdata;
        for (int n = 0; n < TIMEOUT * 3; n++) begin
            if (cmd_ready) begin
                exp_q.push_back(t);
                ok = 1;
                break;
            end
            if (!noted) begin
                saw_full = 1'b1;
                check("full_level", fifo_level, DEPTH);
                noted = 1;
            end
            @(negedge clk);
        end
        if (!ok) check("send_timeout", 0, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        bit done = 0;
        for (int n = 0; n < bound; n++) begin
            if (exp_q.size() == 0 && !busy) begin
                done = 1;
                break;
            end
            @(negedge clk);
        end
        check("drain_done", done, 1);
    endtask

    always @(negedge clk) begin
        logic [7:0] e_rd;
        logic       e_err;
        int         e_en, e_wt;
        if (rst) begin
            en_cnt = 0; wait_cnt = 0; prev_en = 1'b0;
        end else begin
            if (m_enable && !prev_en) begin
                if (exp_q.size() == 0) check("issue_unexpected", 1, 0);
                else begin
                    mon_t = exp_q[0];
                    check("m_addr", m_addr, mon_t.addr);
                    check("m_rw", m_rw, mon_t.rw);
                    if (!mon_t.rw) check("m_data_in", m_data_in, mon_t.wdata);
                end
            end
            prev_en = m_enable;
            if (m_enable) en_cnt++;
            if (busy && !m_enable && !rsp_valid) wait_cnt++;
            if (rsp_valid) begin
                rsp_seen++;
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else begin
                    mon_t = exp_q.pop_front();
                    ref_rsp(mon_t, e_rd, e_err, e_en, e_wt);
                    check("rsp_rdata", rsp_rdata, e_rd);
                    check("rsp_err", rsp_err, e_err);
                    check("enable_cycles", en_cnt, e_en);
                    check("wait_cycles", wait_cnt, e_wt);
                end
                en_cnt = 0; wait_cnt = 0;
            end
        end
    end

    initial begin : master_model
        txn_t t;
        bit abort, got;
        m_ready = 1'b1;
        m_data_out = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && m_enable && exp_q.size() > 0) begin
                t = exp_q[0];
                abort = 0;
                got = 0;
                if (t.mode != M_NOACK) begin
                    for (int i = 0; i < t.d1 && !abort; i++) begin
                        @(negedge clk);
                        abort = rst;
                    end
                    if (!abort) m_ready = 1'b0;
                    if (t.mode == M_NORMAL) begin
                        for (int i = 0; i < t.d2 && !abort; i++) begin
                            @(negedge clk);
                            abort = rst;
                        end
                        m_data_out = t.rw ? t.rd : 8'($urandom);
                        m_ready = 1'b1;
                    end
                end
                for (int i = 0; i < TIMEOUT + 100 && !abort && !got; i++) begin
                    @(negedge clk);
                    abort = rst;
                    got = rsp_valid;
                end
                if (!abort && !got) check("model_rsp_timeout", 0, 1);
                m_ready = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int saved;
        cmd_valid = 1'b0; cmd_addr = 7'h00; cmd_rw = 1'b0; cmd_wdata = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_m_enable", m_enable, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_rw", m_rw, 0);
        check("rst_m_data_in", m_data_in, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_cmd_ready", cmd_ready, 1);

        send(mk(7'h14, 1'b0, 8'hAA, M_NORMAL, 2, 40, 8'h00));
        drain(200);
        send(mk(7'h50, 1'b1, 8'h00, M_NORMAL, 1, 10, 8'hA5));
        drain(200);

        saw_full = 1'b0;
        for (int i = 0; i < 6; i++)
            send(mk(7'($urandom), 1'($urandom), 8'($urandom), M_NORMAL, 1, 30, 8'($urandom)));
        check("burst_full_seen", saw_full, 1);
        drain(1000);
        check("burst_level_empty", fifo_level, 0);
        check("burst_cmd_ready", cmd_ready, 1);

        send(mk(7'h21, 1'b1, 8'h00, M_NOACK, 0, 0, 8'h00));
        send(mk(7'h22, 1'b1, 8'h00, M_NORMAL, 0, 5, 8'h3C));
        drain(300);

        send(mk(7'h33, 1'b0, 8'h5A, M_STUCK, 0, 0, 8'h00));
        drain(TIMEOUT + 200);

        for (int i = 0; i < 40; i++) begin
            send(mk(7'($urandom), 1'($urandom), 8'($urandom),
                    ($urandom_range(0, 9) == 0) ? M_NOACK : M_NORMAL,
                    $urandom_range(0, 5), $urandom_range(1, 20), 8'($urandom)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain(5000);

        send(mk(7'h41, 1'b0, 8'h11, M_NORMAL, 1, 300, 8'h00));
        send(mk(7'h42, 1'b0, 8'h22, M_NORMAL, 1, 5, 8'h00));
        send(mk(7'h43, 1'b1, 8'h00, M_NORMAL, 1, 5, 8'h99));
        for (int n = 0; n < 50; n++) begin
            if (busy && !m_enable && !rsp_valid) break;
            @(negedge clk);
        end
        check("pre_rst_level", fifo_level, 2);
        check("pre_rst_wait_done", busy && !m_enable, 1);
        saved = rsp_seen;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_m_enable", m_enable, 0);
        check("mid_rst_fifo_level", fifo_level, 0);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_busy", busy, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_no_rsp", rsp_seen - saved, 0);
        check("post_rst_m_enable", m_enable, 0);
        check("post_rst_fifo_level", fifo_level, 0);
        check("post_rst_cmd_ready", cmd_ready, 1);

        send(mk(7'h7F, 1'b1, 8'h00, M_NORMAL, 0, 3, 8'hC3));
        drain(200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/i2c_cmd_seq.md
# i2c_cmd_seq

Command sequencer sitting directly upstream of the `i2cm` I2C master. It accepts I2C transactions (address, direction, write byte) from a host over a valid/ready interface and buffers them in a small FIFO. It drives the master's `enable`/`addr`/`rw`/`data_in` one transaction at a time, tracks the master's `ready` handshake with timeouts, and returns one response per command (read byte or error).

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of 2, ≥2.
- `ACK_WAIT`, 16: cycles allowed for `m_ready` to fall after `m_enable` rises.
- `TIMEOUT`, 4096: cycles allowed for `m_ready` to rise again once the master is busy.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  FIFO can accept; equals !full.
- `cmd_addr`  in  7  7-bit slave address.
- `cmd_rw`  in  1  0 = write, 1 = read.
- `cmd_wdata`  in  8  write byte; ignored for reads.
- `rsp_valid`  out  1  one-cycle response strobe; no backpressure.
- `rsp_rdata`  out  8  read byte; 0x00 for writes and errors.
- `rsp_err`  out  1  transaction timed out.
- `m_enable`  out  1  to master `enable`.
- `m_addr`  out  7  to master `addr`.
- `m_rw`  out  1  to master `rw`.
- `m_data_in`  out  8  to master `data_in`.
- `m_data_out`  in  8  from master `data_out`.
- `m_ready`  in  1  from master `ready`; 1 = idle.
- `busy`  out  1  FSM not in IDLE.
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  entries stored.

## Operation
- FIFO: 16-bit entries {rw, addr, wdata}.
  - Push on `cmd_valid & cmd_ready`; no push when full, no write-through.
  - Push and pop in the same cycle: both happen and the level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; an extra pointer bit distinguishes full from empty.
- FSM states:
  - IDLE -> ISSUE when the FIFO is non-empty and `m_ready`=1. On that edge, latch the head into `m_addr`/`m_rw`/`m_data_in`, pop the FIFO and clear the counter.
  - ISSUE: `m_enable`=1 and counter increments.
    - `m_ready`=0 sampled: -> WAIT_DONE, `m_enable`=0, clear counter.
    - Counter reaches ACK_WAIT first: -> RESP with err=1.
  - WAIT_DONE: counter increments.
    - `m_ready`=1 sampled: capture `m_data_out` if `m_rw`=1, otherwise 0x00, then -> RESP with err=0.
    - Counter reaches TIMEOUT first: -> RESP with err=1 and rdata 0x00.
  - RESP: `rsp_valid`=1 for exactly one cycle, then -> IDLE.
- `m_addr`/`m_rw`/`m_data_in` hold their value from the ISSUE latch until the next ISSUE latch.
- Commands complete strictly in FIFO order; one response per accepted command.
- An error does not flush the FIFO; the next command issues normally.

## Timing
- Reset (async assert, sync deassert by clk) leaves every output at 0 except `cmd_ready`=1:
  - `m_enable`, `m_addr`, `m_rw`, `m_data_in` = 0.
  - `rsp_valid`, `rsp_rdata`, `rsp_err` = 0.
  - `busy` = 0, `fifo_level` = 0.
  - FIFO is emptied.
- Reset mid-transaction drops `m_enable` immediately and loses the in-flight and queued commands; no response is produced.
- Command accepted at edge E0 into an empty FIFO with `m_ready`=1: `m_enable` and the master fields are valid after E1.
- `rsp_valid` asserts the cycle after the edge that samples `m_ready`=1 in WAIT_DONE.
- Minimum spacing between `m_enable` assertions is 4 cycles: ISSUE ≥1, WAIT_DONE ≥1, RESP 1, IDLE 1.
- Timeouts:
  - ACK_WAIT: err after exactly ACK_WAIT ISSUE cycles.
  - TIMEOUT: err after exactly TIMEOUT WAIT_DONE cycles.
- `fifo_level` and `cmd_ready` update on the edge following push/pop.

## Test plan
- Single write: addr 0x14, wdata 0xAA, rw 0; master model drops `m_ready` 2 cycles after enable and raises it 40 cycles later -> `m_enable` pulse with `m_addr`=0x14 and `m_data_in`=0xAA, then `rsp_valid` with rdata 0x00, err 0.
- Single read: addr 0x50, rw 1; model returns `m_data_out`=0xA5 -> rsp rdata 0xA5, err 0.
- Burst: 6 back-to-back commands with FIFO_DEPTH=4 and a slow model -> `cmd_ready` drops at level 4, all 6 responses arrive in order, `fifo_level` returns to 0.
- No-ack: model keeps `m_ready`=1 -> `m_enable` high exactly 16 cycles, then rsp err=1, next queued command issues.
- Stuck busy: model holds `m_ready`=0 after enable -> rsp err=1, rdata 0x00, 4096 cycles after entering WAIT_DONE.
- Reset during WAIT_DONE with 2 commands queued -> `m_enable` 0, `fifo_level` 0, `cmd_ready` 1, no `rsp_valid` after release.
